// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
// Holds the FSM state type, display code constants and the digit-count helper.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [5:0] CODE_BLANK = 6'b111111;
    localparam logic [5:0] CODE_ZERO  = 6'b000000;

    // Number of decimal digits needed to show the largest w-bit unsigned value.
    function automatic int digits_for_width(input int w);
        logic [63:0] v;
        int          d;
        v = (64'd1 << w) - 64'd1;
        d = 32'sd1;
        for (int k = 0; k < 20; k++) begin
            if (v >= 64'd10) begin
                v = v / 64'd10;
                d = d + 32'sd1;
            end else begin
                v = v;
            end
        end
        return d;
    endfunction

    // Display code of a visible digit: the decoder takes the value zero-extended.
    function automatic logic [5:0] digit_code(input logic [3:0] d);
        return {2'b00, d};
    endfunction

endpackage

// File: rtl/bcd_adjust.sv
// Double-dabble nibble correction: adds 3 to a BCD digit of 5 or more so the
// following left shift carries correctly into the next decimal digit.
module bcd_adjust (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Conditional add-3; inputs never exceed 9, so the 4-bit sum cannot wrap.
    always_comb begin
        dout = din;
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end else begin
            dout = din;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one bit per clock, with
// registered packed BCD and per-digit 6-bit display codes (optional blanking).
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3,
    parameter int BLANK  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  ready,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [6*DIGITS-1:0]   seg_code
);

    localparam int BW = 4 * DIGITS;
    localparam int SW = BW + WIDTH;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    generate
        if (digits_for_width(WIDTH) > DIGITS) begin : g_digits_too_few
            $error("bin_to_bcd_seq: DIGITS too small for WIDTH");
        end
    endgenerate

    state_e          state_q, state_d;
    logic [SW-1:0]   sr_q, sr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ready_q, ready_d;
    logic            done_q, done_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic [6*DIGITS-1:0] seg_q, seg_d;

    logic [BW-1:0]   adj_s;
    logic [SW-1:0]   pre_shift_s;
    logic [SW-1:0]   sr_shift_s;
    logic [BW-1:0]   result_bcd_s;
    logic [6*DIGITS-1:0] seg_next_s;
    logic            seen_nz_s;
    logic [3:0]      nib_s;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            bcd_adjust u_adj (
                .din  (sr_q[WIDTH + 4*gi +: 4]),
                .dout (adj_s[4*gi +: 4])
            );
        end
    endgenerate

    assign pre_shift_s  = {adj_s, sr_q[WIDTH-1:0]};
    assign sr_shift_s   = pre_shift_s << 1;
    assign result_bcd_s = sr_shift_s[SW-1 -: BW];

    // Display codes for the result, scanning from the most significant digit so
    // a digit is blanked only while every digit above it is also zero.
    always_comb begin
        seen_nz_s  = 1'b0;
        nib_s      = 4'd0;
        seg_next_s = {(6*DIGITS){1'b0}};
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nib_s     = result_bcd_s[4*i +: 4];
            seen_nz_s = seen_nz_s | (nib_s != 4'd0);
            if ((BLANK != 0) && (i > 0) && !seen_nz_s) begin
                seg_next_s[6*i +: 6] = CODE_BLANK;
            end else begin
                seg_next_s[6*i +: 6] = digit_code(nib_s);
            end
        end
    end

    // Next-state and output logic of the IDLE/CONV/DONE controller.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        seg_d   = seg_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CONV;
                    sr_d    = {{BW{1'b0}}, bin};
                    cnt_d   = {CW{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            CONV: begin
                sr_d  = sr_shift_s;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    bcd_d   = result_bcd_s;
                    seg_d   = seg_next_s;
                    done_d  = 1'b1;
                end else begin
                    state_d = CONV;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ready_d = (state_d == IDLE);
    end

    // State, datapath and registered outputs; reset abandons any conversion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= {SW{1'b0}};
            cnt_q   <= {CW{1'b0}};
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            bcd_q   <= {BW{1'b0}};
            seg_q   <= {DIGITS{CODE_ZERO}};
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            bcd_q   <= bcd_d;
            seg_q   <= seg_d;
        end
    end

    assign ready    = ready_q;
    assign done     = done_q;
    assign bcd      = bcd_q;
    assign seg_code = seg_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: one plain and one blanking instance share
// stimulus; expected results are queued at acceptance and checked on done.
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  bin;
    logic        ready0, done0, ready1, done1;
    logic [11:0] bcd0, bcd1;
    logic [17:0] seg0, seg1;

    typedef struct {
        int unsigned acc;
        logic [11:0] bcd;
        logic [17:0] s0;
        logic [17:0] s1;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned cycle_cnt = 0;
    int unsigned last_done_cyc = 0;
    logic [11:0] last_bcd = 12'h000;
    bit          prev_done = 1'b0;
    bit          held_phase = 1'b0;

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3), .BLANK(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
        .ready(ready0), .done(done0), .bcd(bcd0), .seg_code(seg0)
    );

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3), .BLANK(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
        .ready(ready1), .done(done1), .bcd(bcd1), .seg_code(seg1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt = cycle_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, want);
        end
    endtask

    // Reference by repeated division, plus the blanking rule applied top-down.
    function automatic exp_t model(input int unsigned v);
        exp_t        e;
        logic [3:0]  d[3];
        int unsigned t;
        bit          nz;
        t = v;
        for (int i = 0; i < 3; i++) begin
            d[i] = 4'(t % 10);
            t    = t / 10;
        end
        e.acc = 0;
        e.bcd = {d[2], d[1], d[0]};
        nz = 1'b0;
        for (int i = 2; i >= 0; i--) begin
            nz = nz | (d[i] != 4'd0);
            e.s0[6*i +: 6] = {2'b00, d[i]};
            e.s1[6*i +: 6] = (i > 0 && !nz) ? 6'h3F : {2'b00, d[i]};
        end
        return e;
    endfunction

    // Monitor: enqueue on acceptance, dequeue and compare on done.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_done) chk("ready_after_done", {31'd0, ready0}, 32'd1);
            if (done0) begin
                if (sb_q.size() == 0) begin
                    chk("spurious_done", {31'd0, done0}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("latency", cycle_cnt - e.acc, 32'd8);
                    chk("bcd_plain", {20'd0, bcd0}, {20'd0, e.bcd});
                    chk("bcd_blank", {20'd0, bcd1}, {20'd0, e.bcd});
                    chk("seg_plain", {14'd0, seg0}, {14'd0, e.s0});
                    chk("seg_blank", {14'd0, seg1}, {14'd0, e.s1});
                    chk("ready_in_done", {31'd0, ready0}, 32'd0);
                    chk("done_blank", {31'd0, done1}, 32'd1);
                    if (held_phase && last_done_cyc != 0)
                        chk("done_period", cycle_cnt - last_done_cyc, 32'd10);
                    last_done_cyc = cycle_cnt;
                    last_bcd = e.bcd;
                end
            end
            if (ready0 && start) begin
                exp_t e;
                e = model({24'd0, bin});
                e.acc = cycle_cnt + 1;
                sb_q.push_back(e);
            end
            prev_done = done0;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < 40; i++) begin
            if (ready0) break;
            @(posedge clk); #1;
        end
        chk("ready_timeout", {31'd0, ready0}, 32'd1);
    endtask

    task automatic convert(input logic [7:0] v, input bit hold);
        wait_ready();
        bin   = v;
        start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (sb_q.size() == 0 && ready0) break;
            @(posedge clk); #1;
        end
        chk("drain", sb_q.size(), 32'd0);
    endtask

    task automatic chk_idle_reset(input string tag);
        chk({tag, "_ready"}, {31'd0, ready0}, 32'd1);
        chk({tag, "_done"},  {31'd0, done0},  32'd0);
        chk({tag, "_bcd"},   {20'd0, bcd0},   32'd0);
        chk({tag, "_seg0"},  {14'd0, seg0},   32'd0);
        chk({tag, "_seg1"},  {14'd0, seg1},   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        bin   = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle_reset("in_reset");
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk_idle_reset("idle");
        end

        convert(8'd255, 1'b0);
        drain();

        convert(8'd0, 1'b0);
        drain();
        convert(8'd99, 1'b0);
        drain();

        // A start raised while converting must be ignored and not queued.
        convert(8'd200, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        bin   = 8'd7;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("hold_bcd", {20'd0, bcd0}, {20'd0, last_bcd});
        chk("hold_ready", {31'd0, ready0}, 32'd0);
        drain();
        repeat (12) begin @(posedge clk); #1; end

        // Asynchronous reset in the middle of a conversion.
        convert(8'd128, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk_idle_reset("midreset");
        sb_q.delete();
        last_bcd = 12'h000;
        @(posedge clk); #1;
        rst_n = 1'b1;
        convert(8'd128, 1'b0);
        drain();

        // Back-to-back conversions with start held high.
        held_phase    = 1'b1;
        last_done_cyc = 0;
        convert(8'd10, 1'b1);
        convert(8'd11, 1'b1);
        convert(8'd12, 1'b1);
        start = 1'b0;
        drain();
        held_phase = 1'b0;
        repeat (3) begin @(posedge clk); #1; end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) that produces the digit codes consumed by the 6-bit-input seven-segment decoder. It is the producing end of that display-code interface. It accepts an unsigned binary value under a start/ready handshake and emits packed BCD plus one 6-bit display code per digit. Optional leading-zero blanking drives the decoder's all-off default code.

## Interface
- `WIDTH`, default 8: width of the binary input.
- `DIGITS`, default 3: number of BCD digits.
  - Must satisfy 10^DIGITS > 2^WIDTH − 1.
  - An elaboration-time check fails the build otherwise.
- `BLANK`, default 0: when 1, leading zero digits output the blank code.
- `clk` in 1: the single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request a conversion of `bin`; sampled only while `ready` = 1.
- `bin` in WIDTH: unsigned operand, sampled on the accepting edge only.
- `ready` out 1: high in IDLE only.
- `done` out 1: one-cycle pulse; `bcd` and `seg_code` are updated in that cycle.
- `bcd` out 4·DIGITS: packed BCD result; digit 0 (units) is in bits [3:0].
- `seg_code` out 6·DIGITS: per-digit display code; digit i is in bits [6i+5:6i].
  - Non-blanked digit d: code = {2'b00, d}.
  - Blanked digit: code = 6'b111111.

## Operation
- FSM states: IDLE, CONV, DONE.
- IDLE → CONV when `start` = 1 at a clock edge.
  - On that edge: shift register = {4·DIGITS zeros, `bin`}; bit counter = 0.
- CONV, one iteration per edge:
  - Every BCD nibble ≥ 5 gets +3.
  - The whole {bcd, bin} register then shifts left by 1.
  - Counter increments.
- After WIDTH iterations:
  - Registered outputs `bcd` and `seg_code` load the result.
  - State → DONE.
- DONE → IDLE unconditionally on the next edge.
- `start` in CONV or DONE is ignored; it is not queued.
- `bcd`/`seg_code` hold the last result until the next conversion completes. They are not cleared on `start`.
- Blanking (BLANK = 1):
  - Digit i > 0 is blanked iff it and all higher digits are zero.
  - Digit 0 is never blanked, so value 0 shows as "0".
  - `bcd` itself is never blanked.
- Arithmetic width rules:
  - Nibble add-3 is 4-bit and cannot overflow, because inputs are ≤ 9 after adjustment.
  - Counter width is $clog2(WIDTH+1).
- Reset (asynchronous assert, any state, including mid-CONV): conversion is abandoned.
- Reset values:
  - State = IDLE, `ready` = 1, `done` = 0.
  - `bcd` = 0.
  - `seg_code`: each digit = 6'b000000. Blanking is not applied in reset, so all digits show "0".

## Timing
- Accepting edge E0 (`start` = 1 while `ready` = 1): `ready` falls after E0.
- Iterations occur on edges E1…E_WIDTH.
- `done` = 1 and new outputs are valid in the cycle following E_WIDTH.
- `ready` = 1 again after edge E_WIDTH+1.
- Latency from accepting edge to `done` = WIDTH cycles.
- Throughput with `start` held high: one conversion per WIDTH+2 cycles.
- `bin` may change freely after E0.

## Structure
- Package `bcd_pkg`:
  - State enum type (IDLE/CONV/DONE).
  - Constant `CODE_BLANK` = 6'b111111.
  - Function `digits_for_width(w)`, used by the elaboration check.
- Sub-module `bcd_adjust`: combinational, 4-bit in/out, add 3 if ≥ 5. Instantiated DIGITS times via generate.
- Blanking logic and output registers live in the top module.

## Test plan
- Reset, WIDTH = 8, DIGITS = 3: `ready` = 1, `done` = 0, `bcd` = 12'h000, `seg_code` = all 6'b000000. Holds through idle cycles.
- `bin` = 255, `start` pulse:
  - `done` high exactly 8 cycles after the accepting edge.
  - `bcd` = 12'h255; `seg_code` = {6'h02, 6'h05, 6'h05}.
  - `ready` back 1 cycle later.
- `bin` = 0 then `bin` = 99 with BLANK = 1:
  - 0 → codes {6'h3F, 6'h3F, 6'h00}.
  - 99 → codes {6'h3F, 6'h09, 6'h09}, `bcd` = 12'h099.
- `start` pulsed mid-CONV with `bin` = 7 while converting 200:
  - Result 12'h200.
  - No second `done`.
  - Old value held until completion.
- `rst_n` low at iteration 4 of converting 128: `bcd` = 0 and IDLE immediately (asynchronous). A subsequent `start` with 128 yields 12'h128.
- `start` held high, `bin` = 10, 11, 12 sequence: `done` pulses every 10 cycles with 12'h010, 12'h011, 12'h012.
